// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery quotient datapath.
//   state_t   : FSM states (IDLE, RUN, RESOLVE, DONE)
//   W_DEF     : default operand width
//   ceil_div  : integer ceiling division for elaboration-time sizing
package mont_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int W_DEF = 43;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/csa_compress_n.sv
// Compresses N rows of W bits to a carry-save pair (sum, carry) such that
// sum + carry == sum of all rows, mod 2^W.
// Built as a 3:2 CSA tree: each instance applies one level of full-adder
// compression to every complete group of three rows, passes the leftover
// rows through, and recurses on the smaller row set until two remain.
//   rows  : N input rows
//   sum   : output sum vector
//   carry : output carry vector (already shifted, bit W dropped)
module csa_compress_n #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic [W-1:0] rows [N],
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    if (N == 1) begin : g_one
        assign sum   = rows[0];
        assign carry = '0;
    end else if (N == 2) begin : g_two
        assign sum   = rows[0];
        assign carry = rows[1];
    end else begin : g_level
        localparam int G  = N / 3;
        localparam int R  = N % 3;
        localparam int NN = 2 * G + R;

        logic [W-1:0] nxt [NN];

        for (genvar g = 0; g < G; g++) begin : g_fa
            assign nxt[2*g] = rows[3*g] ^ rows[3*g+1] ^ rows[3*g+2];
            // Shift within W bits: the carry out of bit W-1 is discarded (mod 2^W).
            assign nxt[2*g+1] = ((rows[3*g] & rows[3*g+1]) |
                                 (rows[3*g] & rows[3*g+2]) |
                                 (rows[3*g+1] & rows[3*g+2])) << 1;
        end

        for (genvar r = 0; r < R; r++) begin : g_pass
            assign nxt[2*G+r] = rows[3*G+r];
        end

        csa_compress_n #(.N(NN), .W(W)) u_next (
            .rows  (nxt),
            .sum   (sum),
            .carry (carry)
        );
    end

endmodule

// File: rtl/mont_q_digit_serial.sv
// Digit-serial Montgomery quotient generator:
//   q = (a_c + a_s) * p_prime mod 2^W, returned in carry-save form.
// DIGIT bits of p_prime are consumed per RUN cycle; their AND-rows plus the
// running accumulator pair are folded by one csa_compress_n instance.
// Optional macro Q_RESOLVE_EN adds a RESOLVE cycle that carry-propagates the
// pair so q_s holds the full quotient and q_c is 0.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a raised valid holds its data stable until that edge.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (a_c, a_s, p_prime)
//   out_valid/out_ready quotient handshake (q_c, q_s)
//   busy                high whenever the FSM is not in IDLE
module mont_q_digit_serial
    import mont_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DIGIT = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_c,
    input  logic [W-1:0] a_s,
    input  logic [W-1:0] p_prime,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] q_c,
    output logic [W-1:0] q_s,
    output logic         busy
);

    localparam int NCYC  = ceil_div(W, DIGIT);
    localparam int KW    = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam int NROWS = 2 * DIGIT + 2;
    localparam logic [KW-1:0] K_LAST = KW'(NCYC - 1);

    state_t         state;
    logic [KW-1:0]  k;
    logic [W-1:0]   a_c_r, a_s_r, p_r;
    logic [W-1:0]   acc_c, acc_s;
    logic [W-1:0]   rows [NROWS];
    logic [W-1:0]   csa_s, csa_c;
    logic [DIGIT-1:0] p_dig;
    int             base;

    // Row generation for digit k. Shifts of k*DIGIT+j >= W yield zero rows,
    // and the shifted-down p_prime supplies zeros past bit W-1, so the
    // partial last digit needs no special case.
    always_comb begin
        base  = int'(k) * DIGIT;
        p_dig = DIGIT'(p_r >> base);
        for (int j = 0; j < DIGIT; j++) begin
            rows[2*j]   = p_dig[j] ? (a_c_r << (base + j)) : '0;
            rows[2*j+1] = p_dig[j] ? (a_s_r << (base + j)) : '0;
        end
        rows[2*DIGIT]   = acc_c;
        rows[2*DIGIT+1] = acc_s;
    end

    csa_compress_n #(.N(NROWS), .W(W)) u_csa (
        .rows  (rows),
        .sum   (csa_s),
        .carry (csa_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            a_c_r     <= '0;
            a_s_r     <= '0;
            p_r       <= '0;
            acc_c     <= '0;
            acc_s     <= '0;
            q_c       <= '0;
            q_s       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_c_r    <= a_c;
                        a_s_r    <= a_s;
                        p_r      <= p_prime;
                        acc_c    <= '0;
                        acc_s    <= '0;
                        k        <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc_c <= csa_c;
                    acc_s <= csa_s;
                    k     <= k + 1'b1;
                    if (k == K_LAST) begin
`ifdef Q_RESOLVE_EN
                        state <= RESOLVE;
`else
                        state <= DONE;
`endif
                    end
                end
                RESOLVE: begin
`ifdef Q_RESOLVE_EN
                    acc_s <= acc_c + acc_s;
                    acc_c <= '0;
`endif
                    state <= DONE;
                end
                DONE: begin
                    // First DONE cycle loads the output registers; they then
                    // hold until the downstream handshake.
                    if (!out_valid) begin
                        q_c       <= acc_c;
                        q_s       <= acc_s;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
